aes_key_loader: RTL and testbench

AXI-Lite master that programs the AES core's configuration register map. On a single start pulse it writes a 128-bit key and a mode word, then fires the load-pulse register. It sits between the UART command decoder and the `axi_aes_ip` AXI-Lite slave port, so that key/mode setup needs no processor. It reports completion and any slave error back to the command side.

---
 rtl/aes_cfg_pkg.sv | 52 +++++
 rtl/aes_key_loader.sv | 175 +++++++++++++++++
 tb/tb_aes_key_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cfg_pkg.sv
// Shared register map, step constants and FSM state type for the AES configuration path.
// AES_KEY_LOADER_READBACK_EN adds the readback states to the state enum.
package aes_cfg_pkg;

  localparam logic [7:0] AES_REG_KEY0 = 8'h00;
  localparam logic [7:0] AES_REG_KEY1 = 8'h04;
  localparam logic [7:0] AES_REG_KEY2 = 8'h08;
  localparam logic [7:0] AES_REG_KEY3 = 8'h0C;
  localparam logic [7:0] AES_REG_MODE = 8'h10;
  localparam logic [7:0] AES_REG_LOAD = 8'h14;

  localparam int          AES_CFG_STEPS    = 6;
  localparam logic [2:0]  AES_ERR_READBACK = 3'd6;
  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_FINISH
`ifdef AES_KEY_LOADER_READBACK_EN
    ,
    ST_RD_REQ,
    ST_RD_RESP
`endif
  } aes_cfg_state_t;

  function automatic logic [7:0] aesRegOffset(input logic [2:0] step);
    case (step)
      3'd0:    aesRegOffset = AES_REG_KEY0;
      3'd1:    aesRegOffset = AES_REG_KEY1;
      3'd2:    aesRegOffset = AES_REG_KEY2;
      3'd3:    aesRegOffset = AES_REG_KEY3;
      3'd4:    aesRegOffset = AES_REG_MODE;
      default: aesRegOffset = AES_REG_LOAD;
    endcase
  endfunction

  // The word written (and read back) at each step; the final step is the load pulse.
  function automatic logic [31:0] aesStepWord(input logic [127:0] key, input logic [31:0] mode,
                                              input logic [2:0] step);
    case (step)
      3'd0:    aesStepWord = key[31:0];
      3'd1:    aesStepWord = key[63:32];
      3'd2:    aesStepWord = key[95:64];
      3'd3:    aesStepWord = key[127:96];
      3'd4:    aesStepWord = mode;
      default: aesStepWord = 32'h1;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_loader.sv
// AXI-Lite master that writes key, mode and load pulse into the AES core on one start request.
// Define AES_KEY_LOADER_READBACK_EN to verify key/mode by readback before the load pulse.
module aes_key_loader
  import aes_cfg_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [127:0]                    cfg_key,
  input  logic [31:0]                     cfg_mode,
  input  logic                            cfg_start,
  output logic                            cfg_busy,
  output logic                            cfg_done,
  output logic                            cfg_err,
  output logic [2:0]                      cfg_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam logic [2:0] LAST_STEP = 3'(AES_CFG_STEPS - 1);
  localparam logic [2:0] MODE_STEP = LAST_STEP - 3'd1;

  aes_cfg_state_t r_state, w_nextState;
  logic [2:0]     r_step, w_stepNext;
  logic [127:0]   r_key, w_keySrc;
  logic [31:0]    r_mode, w_modeSrc;
  logic           r_awPend, r_wPend;
  logic           r_err, w_errNext;
  logic [2:0]     r_errIdx, w_errIdxNext;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]    r_wdata;
  logic           w_loadReq, w_awDone, w_wDone;

  assign w_awDone  = !r_awPend || m_axi_awready;
  assign w_wDone   = !r_wPend || m_axi_wready;
  // The first write data is chosen in the same cycle the key is latched.
  assign w_keySrc  = (r_state == ST_IDLE) ? cfg_key : r_key;
  assign w_modeSrc = (r_state == ST_IDLE) ? cfg_mode : r_mode;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_stepNext   = r_step;
    w_loadReq    = 1'b0;
    w_errNext    = 1'b0;
    w_errIdxNext = 3'd0;
    case (r_state)
      ST_IDLE: if (cfg_start) begin
        w_nextState = ST_WR_REQ;
        w_stepNext  = 3'd0;
        w_loadReq   = 1'b1;
      end
      ST_WR_REQ: if (w_awDone && w_wDone) w_nextState = ST_WR_RESP;
      ST_WR_RESP: if (m_axi_bvalid) begin
        if (m_axi_bresp != AXI_RESP_OKAY) begin
          w_nextState  = ST_FINISH;
          w_errNext    = 1'b1;
          w_errIdxNext = r_step;
        end else if (r_step == LAST_STEP) begin
          w_nextState = ST_FINISH;
`ifdef AES_KEY_LOADER_READBACK_EN
        end else if (r_step == MODE_STEP) begin
          w_nextState = ST_RD_REQ;
          w_stepNext  = 3'd0;
          w_loadReq   = 1'b1;
`endif
        end else begin
          w_nextState = ST_WR_REQ;
          w_stepNext  = r_step + 3'd1;
          w_loadReq   = 1'b1;
        end
      end
`ifdef AES_KEY_LOADER_READBACK_EN
      ST_RD_REQ: if (m_axi_arready) w_nextState = ST_RD_RESP;
      ST_RD_RESP: if (m_axi_rvalid) begin
        if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rdata != aesStepWord(r_key, r_mode, r_step)) begin
          w_nextState  = ST_FINISH;
          w_errNext    = 1'b1;
          w_errIdxNext = AES_ERR_READBACK;
        end else if (r_step == MODE_STEP) begin
          w_nextState = ST_WR_REQ;
          w_stepNext  = LAST_STEP;
          w_loadReq   = 1'b1;
        end else begin
          w_nextState = ST_RD_REQ;
          w_stepNext  = r_step + 3'd1;
          w_loadReq   = 1'b1;
        end
      end
`endif
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Step, address/data and per-channel valid flags; each flag drops after its own handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_step   <= 3'd0;
      r_key    <= '0;
      r_mode   <= '0;
      r_awPend <= 1'b0;
      r_wPend  <= 1'b0;
      r_err    <= 1'b0;
      r_errIdx <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_step <= w_stepNext;
      if (r_state == ST_IDLE && cfg_start) begin
        r_key  <= cfg_key;
        r_mode <= cfg_mode;
      end
      if (w_loadReq) r_addr <= BASE_ADDR + C_M_AXI_ADDR_WIDTH'(aesRegOffset(w_stepNext));
      if (w_loadReq && w_nextState == ST_WR_REQ) begin
        r_awPend <= 1'b1;
        r_wPend  <= 1'b1;
        r_wdata  <= aesStepWord(w_keySrc, w_modeSrc, w_stepNext);
      end else begin
        if (m_axi_awready) r_awPend <= 1'b0;
        if (m_axi_wready)  r_wPend  <= 1'b0;
      end
      if (w_nextState == ST_FINISH && r_state != ST_FINISH) begin
        r_err    <= w_errNext;
        r_errIdx <= w_errIdxNext;
      end
    end
  end

  assign cfg_busy      = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign cfg_done      = (r_state == ST_FINISH);
  assign cfg_err       = r_err;
  assign cfg_err_idx   = r_errIdx;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awPend;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = r_wPend;
  assign m_axi_bready  = (r_state == ST_WR_RESP);

`ifdef AES_KEY_LOADER_READBACK_EN
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = (r_state == ST_RD_REQ);
  assign m_axi_rready  = (r_state == ST_RD_RESP);
`else
  logic w_unusedRd;
  assign w_unusedRd    = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_loader.sv
// Self-checking bench for aes_key_loader: AXI-Lite slave model with latency/error knobs and a write scoreboard.
// Also exercises the readback abort when AES_KEY_LOADER_READBACK_EN is defined.
module tb_aes_key_loader;

`ifdef AES_KEY_LOADER_READBACK_EN
  localparam int DONE_CYC = 23;
`else
  localparam int DONE_CYC = 13;
`endif

  logic         aclk, areset;
  logic [127:0] cfg_key;
  logic [31:0]  cfg_mode;
  logic         cfg_start, cfg_busy, cfg_done, cfg_err;
  logic [2:0]   cfg_err_idx;
  logic [6:0]   m_axi_awaddr, m_axi_araddr;
  logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]  m_axi_wdata, m_axi_rdata;
  logic [3:0]   m_axi_wstrb;
  logic [1:0]   m_axi_bresp, m_axi_rresp;
  logic         m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic         m_axi_rvalid, m_axi_rready;

  aes_key_loader dut (
    .aclk(aclk), .areset(areset),
    .cfg_key(cfg_key), .cfg_mode(cfg_mode), .cfg_start(cfg_start),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_err_idx(cfg_err_idx),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wrExp_t;

  wrExp_t      expQ[$];
  int          compared = 0;
  int          mismatched = 0;

  int          awLat = 0, wLat = 0, bLat = 0, errAt = -1, corruptAddr = -1;
  int          awWait = 0, wWait = 0, bWait = 0;
  int          awCount = 0, bCount = 0, doneCount = 0;
  bit          awGot = 0, wGot = 0, bHsSeen = 0, arGot = 0, rHsSeen = 0;
  bit          prevAwPend = 0, prevWPend = 0;
  logic [6:0]  capAddr, prevAwAddr, arAddr;
  logic [31:0] capData, prevWData;
  logic [31:0] mem [0:7];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) if (cfg_done) doneCount++;

  // Slave model: decides ready/valid at the falling edge for the next rising edge.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    for (int i = 0; i < 8; i++) mem[i] = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        awGot = 0; wGot = 0; bHsSeen = 0; arGot = 0; rHsSeen = 0;
        awWait = 0; wWait = 0; bWait = 0; prevAwPend = 0; prevWPend = 0;
        continue;
      end
      if (prevAwPend) begin
        checkOutput("awvalidHeld", m_axi_awvalid, 1);
        checkOutput("awaddrHeld", m_axi_awaddr, prevAwAddr);
      end
      if (prevWPend) begin
        checkOutput("wvalidHeld", m_axi_wvalid, 1);
        checkOutput("wdataHeld", m_axi_wdata, prevWData);
      end
      if (m_axi_bvalid && bHsSeen) begin
        m_axi_bvalid = 0; m_axi_bresp = 0;
        awGot = 0; wGot = 0; awWait = 0; wWait = 0; bWait = 0;
        bCount++;
      end else if (awGot && wGot && !m_axi_bvalid) begin
        if (bWait >= bLat) begin
          checkOutput("sbNotEmpty", expQ.size() > 0, 1);
          if (expQ.size() > 0) begin
            wrExp_t e;
            e = expQ.pop_front();
            checkOutput("wrAddr", capAddr, e.addr);
            checkOutput("wrData", capData, e.data);
          end
          mem[capAddr[4:2]] = capData;
          m_axi_bresp  = (bCount == errAt) ? 2'b10 : 2'b00;
          m_axi_bvalid = 1;
        end else bWait++;
      end
      bHsSeen = m_axi_bvalid && m_axi_bready;
      m_axi_awready = 0;
      if (m_axi_awvalid && !awGot) begin
        if (awWait >= awLat) begin
          m_axi_awready = 1; awGot = 1; capAddr = m_axi_awaddr; awCount++;
        end else awWait++;
      end
      m_axi_wready = 0;
      if (m_axi_wvalid && !wGot) begin
        if (wWait >= wLat) begin
          m_axi_wready = 1; wGot = 1; capData = m_axi_wdata;
        end else wWait++;
      end
      if (m_axi_rvalid && rHsSeen) begin
        m_axi_rvalid = 0; arGot = 0;
      end else if (arGot && !m_axi_rvalid) begin
        m_axi_rvalid = 1;
        m_axi_rresp  = 2'b00;
        m_axi_rdata  = (int'(arAddr) == corruptAddr) ? 32'hDEADBEEF : mem[arAddr[4:2]];
      end
      rHsSeen = m_axi_rvalid && m_axi_rready;
      m_axi_arready = 0;
      if (m_axi_arvalid && !arGot) begin
        m_axi_arready = 1; arGot = 1; arAddr = m_axi_araddr;
      end
      prevAwPend = m_axi_awvalid && !m_axi_awready;
      prevAwAddr = m_axi_awaddr;
      prevWPend  = m_axi_wvalid && !m_axi_wready;
      prevWData  = m_axi_wdata;
    end
  end

  task automatic applyStimulus(input logic [127:0] key, input logic [31:0] mode, input int nExp);
    wrExp_t e;
    awCount = 0; bCount = 0; doneCount = 0;
    for (int i = 0; i < nExp; i++) begin
      e.addr = 7'(i * 4);
      if (i < 4)       e.data = key[32*i +: 32];
      else if (i == 4) e.data = mode;
      else             e.data = 32'h1;
      expQ.push_back(e);
    end
    @(negedge aclk);
    cfg_key = key; cfg_mode = mode; cfg_start = 1;
    @(negedge aclk);
    cfg_start = 0;
    checkOutput("awvalidCycle1", m_axi_awvalid, 1);
    checkOutput("wvalidCycle1", m_axi_wvalid, 1);
    checkOutput("awaddrCycle1", m_axi_awaddr, 0);
    checkOutput("busyCycle1", cfg_busy, 1);
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!cfg_done && cyc < 400) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("doneSeen", cfg_done, 1);
    checkOutput("busyAtDone", cfg_busy, 0);
  endtask

  task automatic waitStep(input logic [6:0] addr);
    int n = 0;
    while (!(m_axi_awvalid && m_axi_awaddr == addr) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("reachStep", m_axi_awvalid && m_axi_awaddr == addr, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    areset = 1; cfg_start = 0; cfg_key = '0; cfg_mode = '0;
    repeat (3) @(negedge aclk);
    checkOutput("rstAwvalid", m_axi_awvalid, 0);
    checkOutput("rstWvalid", m_axi_wvalid, 0);
    checkOutput("rstBready", m_axi_bready, 0);
    checkOutput("rstArvalid", m_axi_arvalid, 0);
    checkOutput("rstRready", m_axi_rready, 0);
    checkOutput("rstBusy", cfg_busy, 0);
    checkOutput("rstDone", cfg_done, 0);
    checkOutput("rstErr", {cfg_err, cfg_err_idx}, 0);
    checkOutput("rstAddrData", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 0);
    checkOutput("wstrb", m_axi_wstrb, 4'hF);
    @(posedge aclk); #2 areset = 0;

    $display("[TB] zero-wait sequence");
    applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 32'h0, 6);
    waitDone(cyc);
    checkOutput("doneCycle", cyc, DONE_CYC);
    checkOutput("errClean", cfg_err, 0);
    @(negedge aclk);
    checkOutput("donePulse", cfg_done, 0);
    checkOutput("writes", bCount, 6);
    checkOutput("sbDrained", expQ.size(), 0);

    $display("[TB] skewed slave");
    awLat = 3; wLat = 0; bLat = 2;
    applyStimulus(128'hA5A5_0F0F_1234_5678_9ABC_DEF0_CAFE_F00D, 32'h0000_0003, 6);
    waitDone(cyc);
    checkOutput("skewErr", cfg_err, 0);
    @(negedge aclk);
    checkOutput("skewWrites", bCount, 6);
    checkOutput("skewSbDrained", expQ.size(), 0);
    awLat = 0; bLat = 0;

    $display("[TB] SLVERR on step 2");
    errAt = 2;
    applyStimulus(128'h1111_2222_3333_4444_5555_6666_7777_8888, 32'h5, 3);
    waitDone(cyc);
    checkOutput("slvErr", cfg_err, 1);
    checkOutput("slvErrIdx", cfg_err_idx, 2);
    repeat (10) @(negedge aclk);
    checkOutput("slvErrAwCount", awCount, 3);
    checkOutput("slvErrSbDrained", expQ.size(), 0);
    errAt = -1;

    $display("[TB] start while busy");
    applyStimulus(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 32'h2, 6);
    waitStep(7'h0C);
    @(negedge aclk);
    cfg_key = '1; cfg_mode = 32'hFFFF_FFFF; cfg_start = 1;
    @(negedge aclk);
    cfg_start = 0;
    waitDone(cyc);
    checkOutput("busyStartErr", cfg_err, 0);
    repeat (20) @(negedge aclk);
    checkOutput("busyStartDones", doneCount, 1);
    checkOutput("busyStartWrites", awCount, 6);
    checkOutput("busyStartSbDrained", expQ.size(), 0);

    $display("[TB] reset mid-transaction");
    applyStimulus(128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 32'h1, 6);
    waitStep(7'h04);
    #2 areset = 1;
    #1;
    checkOutput("midRstAwvalid", m_axi_awvalid, 0);
    checkOutput("midRstWvalid", m_axi_wvalid, 0);
    checkOutput("midRstBusy", cfg_busy, 0);
    @(negedge aclk);
    @(posedge aclk); #2 areset = 0;
    expQ.delete();
    applyStimulus(128'h0BAD_F00D_DEAD_C0DE_1357_9BDF_2468_ACE0, 32'h7, 6);
    waitDone(cyc);
    checkOutput("restartDoneCycle", cyc, DONE_CYC);
    checkOutput("restartErr", cfg_err, 0);
    @(negedge aclk);
    checkOutput("restartSbDrained", expQ.size(), 0);

`ifdef AES_KEY_LOADER_READBACK_EN
    $display("[TB] readback corruption at 0x08");
    corruptAddr = 8;
    applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 32'h4, 5);
    waitDone(cyc);
    checkOutput("rbErr", cfg_err, 1);
    checkOutput("rbErrIdx", cfg_err_idx, 6);
    repeat (10) @(negedge aclk);
    checkOutput("rbNoLoad", awCount, 5);
    checkOutput("rbSbDrained", expQ.size(), 0);
    corruptAddr = -1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
